// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core front end: fetch FSM states,
// the buffered fetch entry and the architectural constants used by fetch.
package core_pkg;

  localparam int          ILEN             = 32;
  localparam logic [31:0] NOP              = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Fetch sequencer states.
  //   IDLE  : one cycle after reset before the first request
  //   REQ   : presenting (or waiting for room to present) a request
  //   WAIT  : one request outstanding, its data will be kept
  //   DRAIN : one request outstanding, its data will be thrown away
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [ILEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch unit's bus-level signals: instruction memory
// request/response, decode valid/ready and the execute redirect.
// The master side is the fetch unit; the slave side is its environment.
interface fetch_unit_if #(
  parameter int XLEN = 32
);

  // Instruction memory request/response
  logic            imemReq;
  logic [XLEN-1:0] imemAddr;
  logic            imemRdy;
  logic            imemRvalid;
  logic [XLEN-1:0] imemRdata;

  // Delivery to decode
  logic            instrValid;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instrPc;
  logic            instrReady;

  // Redirect from execute and fault status
  logic            pcSrc;
  logic [XLEN-1:0] pcTarget;
  logic            fetchFault;

  modport master (
    output imemReq, imemAddr,
    input  imemRdy, imemRvalid, imemRdata,
    output instrValid, instr, instrPc,
    input  instrReady,
    input  pcSrc, pcTarget,
    output fetchFault
  );

  modport slave (
    input  imemReq, imemAddr,
    output imemRdy, imemRvalid, imemRdata,
    input  instrValid, instr, instrPc,
    output instrReady,
    output pcSrc, pcTarget,
    input  fetchFault
  );

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, instr} between instruction memory and decode.
// Flush has priority over push and pop in the same cycle.
module fetch_buffer
  import core_pkg::*;
(
  input  logic         clk,
  input  logic         resetN,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [1:0]   count,
  output logic         empty,
  output logic         full
);

  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_push = push && !flush && !full;
  assign do_pop  = pop  && !flush && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge resetN) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples its inputs from before the edge regardless of order.
    if (!resetN) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; occupancy is tracked by
    // count, and an empty slot is never presented downstream.
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end of the RV32I core. Owns the PC, issues one
// word request at a time to instruction memory, buffers returned words in a
// two-entry queue and hands them to decode over valid/ready. A redirect from
// execute flushes the queue and discards any response already in flight.
// Optional build macro FETCH_MISALIGN_CHECK_EN: a redirect to a target that
// is not word aligned raises a sticky fetchFault and halts fetching;
// without it the low two target bits are ignored and fetchFault reads 0.
module fetch_unit
  import core_pkg::*;
#(
  parameter int              XLEN     = ILEN,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
)(
  input  logic         clk,
  input  logic         resetN,
  fetch_unit_if.master bus
);

  localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            pend_q, pend_d;
  logic [XLEN-1:0] pend_target_q, pend_target_d;

  logic [XLEN-1:0] redirect_target;
  logic            outstanding;
  logic            fault;
  logic            req;
  logic            accept;
  logic            buf_push;
  logic            buf_pop;
  logic            buf_flush;
  fetch_entry_t    buf_in;
  fetch_entry_t    buf_head;
  logic [1:0]      buf_count;
  logic            buf_empty;
  logic            buf_full;

  assign redirect_target = bus.pcTarget & WORD_MASK;
  assign outstanding     = (state_q == WAIT) || (state_q == DRAIN);

  // A request already on the bus (pend_q) is never withdrawn, even after a
  // fault; otherwise a new one needs room for its data in the queue.
  assign req = (state_q == REQ) &&
               (pend_q || (!fault &&
                (({1'b0, buf_count} + {2'b00, outstanding}) < 3'd2)));
  assign accept = req && bus.imemRdy;

  // The redirect wins over any decode handshake in the same cycle.
  assign buf_flush = bus.pcSrc;
  assign buf_pop   = bus.instrValid && bus.instrReady && !bus.pcSrc;
  assign buf_in    = '{pc: inflight_pc_q, instr: bus.imemRdata};

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q;

  // Sticky fault on a redirect to a non-word-aligned target.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      fault_q <= 1'b0;
    end else if (bus.pcSrc && (bus.pcTarget[1:0] != 2'b00)) begin
      fault_q <= 1'b1;
    end
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  // Sequencer state, PC and pending-redirect registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      pend_q        <= 1'b0;
      pend_target_q <= RESET_PC;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      pend_q        <= pend_d;
      pend_target_q <= pend_target_d;
    end
  end

  // Next-state logic: request issue, response capture and redirect handling.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    pend_d        = pend_q;
    pend_target_d = pend_target_q;
    buf_push      = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        if (bus.pcSrc) pc_d = redirect_target;
      end

      REQ: begin
        if (accept) begin
          inflight_pc_d = pc_q;
          pend_d        = 1'b0;
          if (bus.pcSrc) begin
            state_d = DRAIN;
            pc_d    = redirect_target;
          end else if (pend_q) begin
            state_d = DRAIN;
            pc_d    = pend_target_q;
          end else begin
            state_d = WAIT;
            pc_d    = pc_q + PC_STEP;
          end
        end else if (bus.pcSrc) begin
          // Keep imemAddr stable while a request is on the bus; remember
          // the target and take it once the old address is accepted.
          if (req) begin
            pend_d        = 1'b1;
            pend_target_d = redirect_target;
          end else begin
            pc_d = redirect_target;
          end
        end
      end

      WAIT: begin
        if (bus.pcSrc) begin
          pc_d = redirect_target;
          // A response landing with the redirect is dropped here and
          // completes the transaction; otherwise wait for it in DRAIN.
          state_d = bus.imemRvalid ? REQ : DRAIN;
        end else if (bus.imemRvalid) begin
          buf_push = !buf_full;
          state_d  = REQ;
        end
      end

      DRAIN: begin
        if (bus.pcSrc)       pc_d    = redirect_target;
        if (bus.imemRvalid)  state_d = REQ;
      end

      default: state_d = IDLE;
    endcase
  end

  fetch_buffer u_buffer (
    .clk       (clk),
    .resetN    (resetN),
    .push      (buf_push),
    .push_data (buf_in),
    .pop       (buf_pop),
    .flush     (buf_flush),
    .head      (buf_head),
    .count     (buf_count),
    .empty     (buf_empty),
    .full      (buf_full)
  );

  assign bus.imemReq    = req;
  assign bus.imemAddr   = pc_q & WORD_MASK;
  assign bus.instrValid = !buf_empty;
  assign bus.instr      = buf_empty ? NOP      : buf_head.instr;
  assign bus.instrPc    = buf_empty ? RESET_PC : buf_head.pc;
  assign bus.fetchFault = fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. A small memory model answers every
// accepted request one cycle later with data 0xC0DE_0000 + address; a
// monitor logs accepted request addresses and decode transfers so the
// directed steps can check ordering, loss and duplication.
module tb_fetch_unit;
  import core_pkg::*;

  logic clk = 1'b0;
  logic resetN;
  logic force_rvalid = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] req_log   [$];
  logic [31:0] dlv_pc    [$];
  logic [31:0] dlv_instr [$];

  fetch_unit_if #(.XLEN(32)) bus ();

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " imemReq"},    32'(bus.imemReq),    32'h0);
    check({tag, " imemAddr"},   bus.imemAddr,        32'h0);
    check({tag, " instrValid"}, 32'(bus.instrValid), 32'h0);
    check({tag, " instr"},      bus.instr,           32'h0000_0013);
    check({tag, " instrPc"},    bus.instrPc,         32'h0);
    check({tag, " fetchFault"}, 32'(bus.fetchFault), 32'h0);
  endtask

  task automatic clear_logs();
    req_log.delete();
    dlv_pc.delete();
    dlv_instr.delete();
  endtask

  // Memory model: one-cycle latency after acceptance.
  initial begin : responder
    logic        acc;
    logic [31:0] acc_addr;
    bus.imemRvalid = 1'b0;
    bus.imemRdata  = 32'h0;
    forever begin
      @(negedge clk);
      acc      = resetN && bus.imemReq && bus.imemRdy;
      acc_addr = bus.imemAddr;
      @(posedge clk);
      #2;
      bus.imemRvalid = acc || force_rvalid;
      bus.imemRdata  = acc ? (32'hC0DE_0000 + acc_addr) : 32'hDEAD_BEEF;
    end
  end

  // Transaction monitor.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (resetN === 1'b1) begin
        if (bus.imemReq && bus.imemRdy) req_log.push_back(bus.imemAddr);
        if (bus.instrValid && bus.instrReady && !bus.pcSrc) begin
          dlv_pc.push_back(bus.instrPc);
          dlv_instr.push_back(bus.instr);
        end
      end
    end
  end

  initial begin : stimulus
    resetN         = 1'b0;
    bus.imemRdy    = 1'b1;
    bus.instrReady = 1'b1;
    bus.pcSrc      = 1'b0;
    bus.pcTarget   = 32'h0;
    step(2);
    check_reset_values("reset");

    // Streaming fetch from reset.
    resetN = 1'b1;
    step();
    check("first req",       32'(bus.imemReq),    32'h1);
    check("first addr",      bus.imemAddr,        32'h0);
    step();
    check("wait no req",     32'(bus.imemReq),    32'h0);
    check("wait no valid",   32'(bus.instrValid), 32'h0);
    step();
    check("first valid",     32'(bus.instrValid), 32'h1);
    check("first instr",     bus.instr,           32'hC0DE_0000);
    check("first pc",        bus.instrPc,         32'h0);
    check("second addr",     bus.imemAddr,        32'h4);
    step();
    check("bubble valid",    32'(bus.instrValid), 32'h0);
    step(6);
    check("stream req cnt",  32'(req_log.size()), 32'd5);
    check("stream req1",     req_log[1],          32'h4);
    check("stream req2",     req_log[2],          32'h8);
    check("stream dlv cnt",  32'(dlv_pc.size()),  32'd4);
    check("stream dlv pc2",  dlv_pc[2],           32'h8);
    check("stream dlv in3",  dlv_instr[3],        32'hC0DE_000C);

    // Decode stall for 10 cycles.
    bus.instrReady = 1'b0;
    clear_logs();
    step(10);
    check("stall req cnt",   32'(req_log.size()), 32'd1);
    check("stall req addr",  req_log[0],          32'h14);
    check("stall no req",    32'(bus.imemReq),    32'h0);
    check("stall valid",     32'(bus.instrValid), 32'h1);
    check("stall hold pc",   bus.instrPc,         32'h10);
    check("stall hold in",   bus.instr,           32'hC0DE_0010);
    bus.instrReady = 1'b1;
    dlv_pc.delete();
    dlv_instr.delete();
    step(4);
    check("release dlv cnt", 32'(dlv_pc.size()),  32'd3);
    check("release pc0",     dlv_pc[0],           32'h10);
    check("release pc1",     dlv_pc[1],           32'h14);
    check("release in1",     dlv_instr[1],        32'hC0DE_0014);
    check("release pc2",     dlv_pc[2],           32'h18);
    check("release req cnt", 32'(req_log.size()), 32'd3);
    check("release req2",    req_log[2],          32'h1C);

    // Redirect while waiting; the 0x1C response lands in the same cycle.
    bus.pcSrc    = 1'b1;
    bus.pcTarget = 32'h100;
    clear_logs();
    step();
    bus.pcSrc = 1'b0;
    check("redir req",       32'(bus.imemReq),    32'h1);
    check("redir addr",      bus.imemAddr,        32'h100);
    check("redir flushed",   32'(bus.instrValid), 32'h0);
    step(2);
    check("redir valid",     32'(bus.instrValid), 32'h1);
    check("redir pc",        bus.instrPc,         32'h100);
    check("redir instr",     bus.instr,           32'hC0DE_0100);
    check("redir no stale",  32'(dlv_pc.size()),  32'd0);

    // Memory not ready for 5 cycles, redirect to 0x200 in the middle.
    bus.imemRdy = 1'b0;
    clear_logs();
    step();
    check("hold addr a",     bus.imemAddr,        32'h104);
    check("hold req a",      32'(bus.imemReq),    32'h1);
    step();
    check("hold addr b",     bus.imemAddr,        32'h104);
    bus.pcSrc    = 1'b1;
    bus.pcTarget = 32'h200;
    step();
    bus.pcSrc = 1'b0;
    check("hold addr c",     bus.imemAddr,        32'h104);
    check("hold req c",      32'(bus.imemReq),    32'h1);
    check("hold flushed",    32'(bus.instrValid), 32'h0);
    step();
    check("hold addr d",     bus.imemAddr,        32'h104);
    step();
    check("hold addr e",     bus.imemAddr,        32'h104);
    bus.imemRdy = 1'b1;
    step();
    check("drain no req",    32'(bus.imemReq),    32'h0);
    step();
    check("target req",      32'(bus.imemReq),    32'h1);
    check("target addr",     bus.imemAddr,        32'h200);
    check("drain dropped",   32'(bus.instrValid), 32'h0);
    step(2);
    check("target valid",    32'(bus.instrValid), 32'h1);
    check("target pc",       bus.instrPc,         32'h200);
    check("target instr",    bus.instr,           32'hC0DE_0200);
    check("target req cnt",  32'(req_log.size()), 32'd2);
    check("target req0",     req_log[0],          32'h104);
    check("target req1",     req_log[1],          32'h200);
    check("target dlv cnt",  32'(dlv_pc.size()),  32'd1);

    // PC wrap at the top of the address space.
    bus.pcSrc    = 1'b1;
    bus.pcTarget = 32'hFFFF_FFFC;
    clear_logs();
    step();
    bus.pcSrc = 1'b0;
    check("wrap drain req",  32'(bus.imemReq),    32'h0);
    check("wrap flushed",    32'(bus.instrValid), 32'h0);
    step();
    check("wrap top addr",   bus.imemAddr,        32'hFFFF_FFFC);
    step(2);
    check("wrap valid",      32'(bus.instrValid), 32'h1);
    check("wrap pc",         bus.instrPc,         32'hFFFF_FFFC);
    check("wrap instr",      bus.instr,           32'hC0DD_FFFC);
    check("wrap next addr",  bus.imemAddr,        32'h0);
    check("wrap next req",   32'(bus.imemReq),    32'h1);
    check("wrap no dlv",     32'(dlv_pc.size()),  32'd0);

    // Misaligned redirect target.
    bus.pcSrc    = 1'b1;
    bus.pcTarget = 32'h102;
    step();
    bus.pcSrc = 1'b0;
    check("misal drain req", 32'(bus.imemReq),    32'h0);
    check("misal flushed",   32'(bus.instrValid), 32'h0);
    step();
`ifdef FETCH_MISALIGN_CHECK_EN
    check("fault set",       32'(bus.fetchFault), 32'h1);
    check("fault no req",    32'(bus.imemReq),    32'h0);
    step(3);
    check("fault sticky",    32'(bus.fetchFault), 32'h1);
    check("fault still idle",32'(bus.imemReq),    32'h0);
    check("fault no valid",  32'(bus.instrValid), 32'h0);
`else
    check("align req",       32'(bus.imemReq),    32'h1);
    check("align addr",      bus.imemAddr,        32'h100);
    check("align no fault",  32'(bus.fetchFault), 32'h0);
`endif

    // Reset mid-transaction, then stray responses in IDLE and REQ.
    resetN = 1'b0;
    #1;
    check_reset_values("mid reset");
    step();
    resetN       = 1'b1;
    force_rvalid = 1'b1;
    step();
    check("rerun req",       32'(bus.imemReq),    32'h1);
    check("rerun addr",      bus.imemAddr,        32'h0);
    step();
    force_rvalid = 1'b0;
    check("stray ignored",   32'(bus.instrValid), 32'h0);
    step();
    check("rerun valid",     32'(bus.instrValid), 32'h1);
    check("rerun instr",     bus.instr,           32'hC0DE_0000);
    check("rerun pc",        bus.instrPc,         32'h0);
    check("rerun no fault",  32'(bus.fetchFault), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
